// File: rtl/control_decoder_pkg.sv
// Shared opcode constants, datapath-select encodings and the control bundle
// used by the instruction decoder and its pipeline register.
package control_decoder_pkg;

  typedef enum logic [6:0] {
    OP_ARI_RTYPE = 7'b0110011,
    OP_ARI_ITYPE = 7'b0010011,
    OP_LOAD      = 7'b0000011,
    OP_STORE     = 7'b0100011,
    OP_BRANCH    = 7'b1100011,
    OP_LUI       = 7'b0110111,
    OP_AUIPC     = 7'b0010111,
    OP_JAL       = 7'b1101111,
    OP_JALR      = 7'b1100111
  } opcode_e;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'b00,
    SRC_A_ZERO = 2'b01
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2 = 2'b00,
    SRC_B_IMM = 2'b01
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALU_OP_ADD    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_RTYPE  = 2'b10,
    ALU_OP_ITYPE  = 2'b11
  } alu_op_e;

  // All-zero value of this bundle is the pipeline bubble: no side effects.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Purely combinational RV32I opcode to datapath-control decode.
module control_decode
  import control_decoder_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ARI_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_RTYPE;
      end
      OP_ARI_ITYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ITYPE;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src_b  = SRC_B_IMM;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      OP_BRANCH: begin
        ctrl.pc_src = 1'b1;
        ctrl.alu_op = ALU_OP_BRANCH;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = SRC_A_ZERO;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      // Jump targets are formed outside this block, so pc_src stays low.
      OP_AUIPC, OP_JAL, OP_JALR: begin
        ctrl.reg_write = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_decoder.sv
// Instruction control decoder: combinational decode plus a pipeline register
// bank with flush (bubble insert) priority over advance.
module control_decoder
  import control_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       en,
  input  logic       flush,
  output logic       reg_write,
  output logic       mem_write,
  output logic       mem_read,
  output logic       mem_to_reg,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic       reg_write_q,
  output logic       mem_write_q,
  output logic       mem_read_q,
  output logic       mem_to_reg_q,
  output logic       pc_src_q,
  output logic [1:0] alu_src_a_q,
  output logic [1:0] alu_src_b_q,
  output logic [1:0] alu_op_q,
  output logic       illegal_q
);

  ctrl_t ctrl;
  ctrl_t ctrl_q;

  control_decode u_decode (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
    end else if (en) begin
      ctrl_q <= ctrl;
    end
  end

  assign reg_write  = ctrl.reg_write;
  assign mem_write  = ctrl.mem_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal    = ctrl.illegal;

  assign reg_write_q  = ctrl_q.reg_write;
  assign mem_write_q  = ctrl_q.mem_write;
  assign mem_read_q   = ctrl_q.mem_read;
  assign mem_to_reg_q = ctrl_q.mem_to_reg;
  assign pc_src_q     = ctrl_q.pc_src;
  assign alu_src_a_q  = ctrl_q.alu_src_a;
  assign alu_src_b_q  = ctrl_q.alu_src_b;
  assign alu_op_q     = ctrl_q.alu_op;
  assign illegal_q    = ctrl_q.illegal;

endmodule

// File: tb/tb_control_decoder.sv
// Directed self-checking bench for control_decoder: decode table, register
// capture/hold/flush behaviour and asynchronous reset.
module tb_control_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       en;
  logic       flush;
  logic       reg_write, mem_write, mem_read, mem_to_reg, pc_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write_q, mem_write_q, mem_read_q, mem_to_reg_q, pc_src_q, illegal_q;
  logic [1:0] alu_src_a_q, alu_src_b_q, alu_op_q;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Packed view: {reg_write, mem_write, mem_read, mem_to_reg, pc_src,
  //               alu_src_a, alu_src_b, alu_op, illegal}
  logic [11:0] comb_vec;
  logic [11:0] q_vec;

  assign comb_vec = {reg_write, mem_write, mem_read, mem_to_reg, pc_src,
                     alu_src_a, alu_src_b, alu_op, illegal};
  assign q_vec    = {reg_write_q, mem_write_q, mem_read_q, mem_to_reg_q, pc_src_q,
                     alu_src_a_q, alu_src_b_q, alu_op_q, illegal_q};

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [11:0] EXP_RTYPE  = 12'b1_0_0_0_0_00_00_10_0;
  localparam logic [11:0] EXP_ITYPE  = 12'b1_0_0_0_0_00_01_11_0;
  localparam logic [11:0] EXP_LOAD   = 12'b1_0_1_1_0_00_01_00_0;
  localparam logic [11:0] EXP_STORE  = 12'b0_1_0_0_0_00_01_00_0;
  localparam logic [11:0] EXP_BRANCH = 12'b0_0_0_0_1_00_00_01_0;
  localparam logic [11:0] EXP_LUI    = 12'b1_0_0_0_0_01_01_00_0;
  localparam logic [11:0] EXP_JUMPS  = 12'b1_0_0_0_0_00_00_00_0;
  localparam logic [11:0] EXP_ILL    = 12'b0_0_0_0_0_00_00_00_1;

  typedef struct {
    string       tag;
    logic [6:0]  opc;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[11];

  control_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .en           (en),
    .flush        (flush),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_to_reg   (mem_to_reg),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .illegal      (illegal),
    .reg_write_q  (reg_write_q),
    .mem_write_q  (mem_write_q),
    .mem_read_q   (mem_read_q),
    .mem_to_reg_q (mem_to_reg_q),
    .pc_src_q     (pc_src_q),
    .alu_src_a_q  (alu_src_a_q),
    .alu_src_b_q  (alu_src_b_q),
    .alu_op_q     (alu_op_q),
    .illegal_q    (illegal_q)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"rtype",   OPC_RTYPE,  EXP_RTYPE};
    vecs[1]  = '{"itype",   OPC_ITYPE,  EXP_ITYPE};
    vecs[2]  = '{"load",    OPC_LOAD,   EXP_LOAD};
    vecs[3]  = '{"store",   OPC_STORE,  EXP_STORE};
    vecs[4]  = '{"branch",  OPC_BRANCH, EXP_BRANCH};
    vecs[5]  = '{"lui",     OPC_LUI,    EXP_LUI};
    vecs[6]  = '{"auipc",   OPC_AUIPC,  EXP_JUMPS};
    vecs[7]  = '{"jal",     OPC_JAL,    EXP_JUMPS};
    vecs[8]  = '{"jalr",    OPC_JALR,   EXP_JUMPS};
    vecs[9]  = '{"ill_7f",  7'h7f,      EXP_ILL};
    vecs[10] = '{"ill_00",  7'h00,      EXP_ILL};

    rst    = 1'b1;
    en     = 1'b0;
    flush  = 1'b0;
    opcode = 7'h00;
    #3;
    check_eq("reset_q", 32'(q_vec), 32'h0);

    // Decode table exercised while rst is held: combinational path ignores it.
    foreach (vecs[i]) begin
      opcode = vecs[i].opc;
      #1;
      check_eq({"comb_", vecs[i].tag}, 32'(comb_vec), 32'(vecs[i].exp));
    end

    opcode = OPC_LOAD;
    en     = 1'b1;
    step();
    check_eq("rst_blocks_capture", 32'(q_vec), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    step();
    check_eq("idle_after_rst", 32'(q_vec), 32'h0);

    @(negedge clk);
    en = 1'b1;
    opcode = OPC_LOAD;
    step();
    check_eq("load_q", 32'(q_vec), 32'(EXP_LOAD));
    check_eq("mem_read_q", 32'(mem_read_q), 32'd1);
    check_eq("mem_to_reg_q", 32'(mem_to_reg_q), 32'd1);
    check_eq("reg_write_q", 32'(reg_write_q), 32'd1);

    @(negedge clk);
    en = 1'b0;
    opcode = OPC_STORE;
    step();
    check_eq("hold_q", 32'(q_vec), 32'(EXP_LOAD));
    check_eq("comb_while_hold", 32'(comb_vec), 32'(EXP_STORE));

    @(negedge clk);
    en = 1'b1;
    opcode = OPC_RTYPE;
    step();
    check_eq("rtype_q", 32'(q_vec), 32'(EXP_RTYPE));

    @(negedge clk);
    flush = 1'b1;
    opcode = OPC_BRANCH;
    step();
    check_eq("flush_over_en", 32'(q_vec), 32'h0);

    @(negedge clk);
    flush = 1'b0;
    step();
    check_eq("branch_q", 32'(q_vec), 32'(EXP_BRANCH));

    @(negedge clk);
    flush = 1'b1;
    en = 1'b0;
    step();
    check_eq("flush_no_en", 32'(q_vec), 32'h0);

    @(negedge clk);
    flush = 1'b0;
    en = 1'b1;
    opcode = OPC_LUI;
    step();
    check_eq("lui_q", 32'(q_vec), 32'(EXP_LUI));

    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_q", 32'(q_vec), 32'h0);
    rst = 1'b0;
    opcode = OPC_ITYPE;
    #1;
    check_eq("q_after_rst_release", 32'(q_vec), 32'h0);
    step();
    check_eq("first_capture_itype", 32'(q_vec), 32'(EXP_ITYPE));

    @(negedge clk);
    opcode = 7'h7f;
    step();
    check_eq("illegal_q", 32'(q_vec), 32'(EXP_ILL));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_decoder.md
CONTROL_DECODER -- requirements
Module: control

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; sole clock domain.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: opcode  input  7  instruction bits [6:0].
REQ-004 SHALL have port: en  input  1  pipeline advance; capture the decode into the _q registers.
REQ-005 SHALL have port: flush  input  1  load a bubble (all-zero) into the _q registers.
REQ-006 SHALL have combinational outputs: reg_write, mem_write, mem_read, mem_to_reg, pc_src (1 bit each), alu_src_a (2), alu_src_b (2), alu_op (2), illegal (1).
REQ-007 SHALL have registered copies of every REQ-006 output, suffixed _q, with the same widths.
REQ-008 SHALL use these encodings:
- alu_src_a: 00 = rs1, 01 = zero.
- alu_src_b: 00 = rs2, 01 = immediate.
- alu_op: 00 = add, 01 = branch compare, 10 = R-type funct decode, 11 = I-type funct decode.

Function
REQ-009 SHALL decode opcode combinationally; outputs settle within the same delta cycle, with no clock dependence.
REQ-010 SHALL recognize these RV32I opcodes:
- ARI_RTYPE 0110011, ARI_ITYPE 0010011
- LOAD 0000011, STORE 0100011, BRANCH 1100011
- LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
REQ-011 SHALL drive reg_write=1 for ARI_ITYPE, ARI_RTYPE, LOAD, LUI, AUIPC, JAL and JALR, and reg_write=0 for STORE and BRANCH.
REQ-012 SHALL drive alu_src_a=01 for LUI and 00 for every other recognized opcode.
REQ-013 SHALL drive alu_src_b=01 for ARI_ITYPE, LOAD, STORE and LUI, and 00 for ARI_RTYPE, BRANCH, AUIPC, JAL and JALR.
REQ-014 SHALL drive mem_write=1 only for STORE.
REQ-015 SHALL drive mem_read=1 and mem_to_reg=1 only for LOAD.
REQ-016 SHALL drive pc_src=1 only for BRANCH; JAL and JALR drive pc_src=0, because the jump target path lies outside this block.
REQ-017 SHALL drive alu_op as follows: ARI_ITYPE 11, ARI_RTYPE 10, BRANCH 01, all others 00.
REQ-018 For any unrecognized opcode, SHALL drive all control outputs to 0 and illegal=1; for recognized opcodes illegal=0.
REQ-019 On a rising clk edge, SHALL update the _q registers as follows:
- flush=1: load all zeros (flush has priority over en).
- flush=0, en=1: load the current combinational decode.
- otherwise: hold.
REQ-020 The all-zero bubble SHALL have no architectural side effects: no register write, no memory access, no branch.

Reset
REQ-021 While rst=1, all _q outputs SHALL be 0 immediately, independent of clk.
REQ-022 The combinational outputs SHALL be unaffected by rst.
REQ-023 After rst deasserts mid-operation, the first capture SHALL occur at the next rising clk edge with en=1.

Structure
REQ-024 Opcode constants and the alu_src_a, alu_src_b and alu_op encodings SHALL live in the shared opcode package or header.
REQ-025 SHALL use one sub-module, control_decode, which is purely combinational (opcode to controls), instantiated inside control beside the _q register bank.

Verification
REQ-026 Each of the nine opcodes applied, check after 1 ns -> every combinational output matches REQ-011..REQ-017 (e.g. STORE: reg_write=0, mem_write=1, alu_src_b=01, pc_src=0).
REQ-027 LUI -> alu_src_a=01, alu_src_b=01, reg_write=1, alu_op=00; AUIPC -> alu_src_a=00, alu_src_b=00.
REQ-028 opcode=1111111 -> illegal=1 and all controls 0.
REQ-029 LOAD with en=1, then a clk edge -> mem_read_q=1, mem_to_reg_q=1, reg_write_q=1; next edge with en=0 and opcode=STORE -> values held.
REQ-030 flush=1 and en=1 with opcode=BRANCH at a clk edge -> all _q outputs 0.
REQ-031 rst pulsed between clk edges while _q outputs are nonzero -> all _q outputs 0 at once, with no clock edge required.
